ft601_tx_arbiter: RTL and testbench
===================================

# ft601_tx_arbiter

Round-robin scheduler that shares the FT601 write path among NUM_PERIPHS peripheral TX FIFOs. It sits between the per-peripheral first-word-fall-through (FWFT) FIFOs and the FT601 controller. It presents one granted FIFO's head word on `data_o` with `periph_data_available`, and pops that FIFO when the controller asserts `read_periph_data`. Grants rotate fairly, and each grant is capped at BURST_MAX words so that no peripheral starves the others.

## Interface
- NUM_PERIPHS, default 8: number of requesting FIFOs; minimum 2.
- BURST_MAX, default 16: maximum words popped per grant; minimum 1.
- IDW: derived as $clog2(NUM_PERIPHS). It is a localparam, not overridable.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- fifo_empty  in  NUM_PERIPHS  per-FIFO empty flag.
- fifo_data  in  32*NUM_PERIPHS  FWFT head words; FIFO i occupies bits [32*i+31:32*i].
- fifo_init_done  in  NUM_PERIPHS  per-FIFO initialization complete.
- fifo_rd  out  NUM_PERIPHS  one-hot pop strobe.
- periph_ready  out  1  registered AND of all fifo_init_done bits.
- periph_data_available  out  1  `data_o` holds a valid word this cycle.
- data_o  out  32  head word of the granted FIFO.
- read_periph_data  in  1  controller consumes `data_o` this cycle.
- grant_id  out  IDW  index of the current or most recent grant.

## Operation
Internal state:
- state: IDLE or ACTIVE.
- grant: IDW bits.
- last_grant: IDW bits.
- burst_cnt: $clog2(BURST_MAX+1) bits.
- periph_ready register.

IDLE:
- Outputs: `periph_data_available`=0, `fifo_rd`=0, `data_o`=0.
- If `periph_ready`=1 and any `fifo_empty` bit is 0, select the first non-empty index searching from last_grant+1 upward, wrapping modulo NUM_PERIPHS.
- On selection: grant<=that index, last_grant<=that index, burst_cnt<=0, go to ACTIVE.

ACTIVE:
- `data_o`=fifo_data[grant].
- `periph_data_available`=!fifo_empty[grant].
- `fifo_rd[grant]`=`read_periph_data` && `periph_data_available`. All other `fifo_rd` bits are 0.
- Each pop increments burst_cnt.
- Go to IDLE next cycle if either:
  - the pop this cycle makes burst_cnt reach BURST_MAX, or
  - fifo_empty[grant]=1 this cycle.

Handshake and flow rules:
- `read_periph_data` while `periph_data_available`=0 is ignored: no pop, no count.
- No pop ever occurs on a non-granted or empty FIFO.
- A word is consumed exactly once, in the cycle that `read_periph_data` and `periph_data_available` are both 1.

periph_ready:
- `periph_ready`<=&fifo_init_done every cycle.
- If `periph_ready`=0 while ACTIVE: force `periph_data_available`=0 and `fifo_rd`=0 that cycle, and go to IDLE. burst_cnt is discarded.

Search and rotation:
- When last_grant=NUM_PERIPHS-1, the search wraps to index 0.
- If only last_grant is non-empty, it is re-granted, with a fresh burst.

`grant_id`=grant. It holds its value in IDLE.

Reset (synchronous, on rst=1):
- state=IDLE.
- grant=0, last_grant=NUM_PERIPHS-1, so the first search starts at index 0.
- burst_cnt=0, periph_ready=0.
- Resulting outputs: `fifo_rd`=0, `periph_data_available`=0, `data_o`=0, `grant_id`=0.
- Reset asserted mid-burst takes effect at the next edge. No pop occurs in a cycle where rst=1.

## Timing
- `periph_ready` rises 1 cycle after the last `fifo_init_done` bit rises.
- Request to data: a FIFO seen non-empty in IDLE at edge N is granted at edge N+1. `data_o` and `periph_data_available` are valid during cycle N+1 (combinational from the FWFT head).
- Sustained rate: one word per cycle while `read_periph_data`=1 and the granted FIFO stays non-empty.
- Grant switch overhead: exactly 1 IDLE cycle between any two grants, including a re-grant of the same FIFO.
- The pop that reaches BURST_MAX and the IDLE transition happen on the same edge. The next word appears 2 cycles after the final pop.
- If a FIFO empties on the edge after its last pop, ACTIVE lasts 1 extra cycle with `periph_data_available`=0, then the block returns to IDLE.

## Test plan
- Init gating: `fifo_init_done` bits rise one at a time while FIFO 3 holds data. Required: `periph_ready`=1 and no grant until 1 cycle after the final bit; FIFO 3 granted the cycle after that.
- Round-robin: FIFOs 1, 4, 6 each hold 2 words; `read_periph_data` held at 1. Required: grant order 1,4,6; 6 words delivered in order; one IDLE cycle between grants; all `fifo_rd` pulses one-hot.
- Burst cap: BURST_MAX=16; FIFO 0 holds 40 words, FIFO 2 holds 5. Required: sequence 16 from FIFO 0, 5 from FIFO 2, 16 from FIFO 0, then 8 from FIFO 0.
- Backpressure: `read_periph_data` toggles 1,0,0,1 during a grant. Required: pops only on cycles where it is 1; `data_o` held stable while it is 0; burst_cnt unchanged on non-pop cycles.
- Wrap and readiness loss: last_grant=7 with FIFOs 0 and 7 non-empty; clear `fifo_init_done[5]` mid-burst. Required: FIFO 0 granted first; pops stop the same cycle `periph_ready` falls; IDLE next cycle; no grants until `periph_ready` returns.
- Reset mid-burst: assert rst during the 5th word of a burst. Required: at the next edge, all outputs return to reset values; after release, the search restarts at index 0.

Source files
------------

// File: rtl/ft601_tx_arbiter.sv
// ft601_tx_arbiter
//
// Round-robin scheduler that shares the FT601 write path among NUM_PERIPHS
// first-word-fall-through TX FIFOs. One FIFO at a time is granted. Its head
// word is shown on data_o, and the FIFO is popped whenever the FT601
// controller consumes that word. A grant ends when the FIFO runs dry, when
// BURST_MAX words have been taken, or when the peripherals drop out of
// readiness. Exactly one IDLE cycle separates consecutive grants.
//
// Ports:
//   clk                    single clock, rising edge
//   rst                    synchronous, active-high reset
//   fifo_empty     [N]     per-FIFO empty flag
//   fifo_data      [32*N]  FWFT head words, FIFO i at [32*i+31:32*i]
//   fifo_init_done [N]     per-FIFO initialisation complete
//   fifo_rd        [N]     one-hot pop strobe (combinational)
//   periph_ready           registered AND of fifo_init_done
//   periph_data_available  data_o carries a valid word this cycle
//   data_o         [32]    head word of the granted FIFO (0 when IDLE)
//   read_periph_data       controller consumes data_o this cycle
//   grant_id       [IDW]   current or most recent grant
//
// Handshake: periph_data_available is the valid and read_periph_data is the
// ready. A word transfers, and its FIFO is popped, only in a cycle where both
// are 1. A read with valid low is ignored. Valid never depends on ready.

module ft601_tx_arbiter #(
    parameter int NUM_PERIPHS = 8,
    parameter int BURST_MAX   = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PERIPHS-1:0]          fifo_empty,
    input  logic [32*NUM_PERIPHS-1:0]       fifo_data,
    input  logic [NUM_PERIPHS-1:0]          fifo_init_done,
    output logic [NUM_PERIPHS-1:0]          fifo_rd,
    output logic                            periph_ready,
    output logic                            periph_data_available,
    output logic [31:0]                     data_o,
    input  logic                            read_periph_data,
    output logic [$clog2(NUM_PERIPHS)-1:0]  grant_id
);

    localparam int IDW = $clog2(NUM_PERIPHS);
    localparam int BCW = $clog2(BURST_MAX + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t          state;
    logic [IDW-1:0]  grant;
    logic [IDW-1:0]  last_grant;
    logic [BCW-1:0]  burst_cnt;

    logic [31:0]     words [NUM_PERIPHS];
    logic [IDW-1:0]  next_idx;
    logic [IDW-1:0]  cand;
    logic            found;
    logic            head_empty;
    logic            pop;
    logic            last_pop;

    always_comb begin
        for (int i = 0; i < NUM_PERIPHS; i++) begin
            words[i] = fifo_data[32*i +: 32];
        end
    end

    // Rotating priority search: the first non-empty FIFO from last_grant+1
    // upward, wrapping. The final candidate is last_grant itself, so a lone
    // requester is re-granted.
    always_comb begin
        next_idx = '0;
        cand     = '0;
        found    = 1'b0;
        for (int k = 1; k <= NUM_PERIPHS; k++) begin
            cand = IDW'((int'(last_grant) + k) % NUM_PERIPHS);
            if (!found && !fifo_empty[cand]) begin
                next_idx = cand;
                found    = 1'b1;
            end
        end
    end

    assign head_empty = fifo_empty[grant];

    // Valid is also gated by rst so that no word is handed over (or popped)
    // in a cycle that is about to be discarded by reset.
    always_comb begin
        periph_data_available = (state == ACTIVE) && periph_ready && !rst && !head_empty;
        pop                   = periph_data_available && read_periph_data;
        fifo_rd               = '0;
        if (pop) begin
            fifo_rd[grant] = 1'b1;
        end
        data_o = (state == ACTIVE) ? words[grant] : 32'h0;
    end

    // The pop that brings burst_cnt up to BURST_MAX also closes the grant.
    assign last_pop = pop && (burst_cnt == BCW'(BURST_MAX - 1));
    assign grant_id = grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            grant        <= '0;
            last_grant   <= IDW'(NUM_PERIPHS - 1);
            burst_cnt    <= '0;
            periph_ready <= 1'b0;
        end else begin
            periph_ready <= &fifo_init_done;
            case (state)
                IDLE: begin
                    if (periph_ready && found) begin
                        grant      <= next_idx;
                        last_grant <= next_idx;
                        burst_cnt  <= '0;
                        state      <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (!periph_ready || head_empty) begin
                        state     <= IDLE;
                        burst_cnt <= '0;
                    end else if (pop) begin
                        burst_cnt <= burst_cnt + BCW'(1);
                        if (last_pop) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ft601_tx_arbiter.sv
// Testbench for ft601_tx_arbiter (NUM_PERIPHS=8, BURST_MAX=16).
// Queues model the FWFT FIFOs. Per-cycle vector tables cover init gating,
// round-robin, backpressure and wrap/readiness loss. Hand-written sequences
// cover the burst cap and reset mid-burst.

module tb_ft601_tx_arbiter;

  localparam int N = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  fifo_empty;
  logic [32*N-1:0] fifo_data;
  logic [N-1:0]  fifo_init_done;
  logic [N-1:0]  fifo_rd;
  logic          periph_ready;
  logic          periph_data_available;
  logic [31:0]   data_o;
  logic          read_periph_data;
  logic [2:0]    grant_id;

  ft601_tx_arbiter #(
    .NUM_PERIPHS(8),
    .BURST_MAX(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fifo_empty(fifo_empty),
    .fifo_data(fifo_data),
    .fifo_init_done(fifo_init_done),
    .fifo_rd(fifo_rd),
    .periph_ready(periph_ready),
    .periph_data_available(periph_data_available),
    .data_o(data_o),
    .read_periph_data(read_periph_data),
    .grant_id(grant_id)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        rd;
    logic [7:0]  init;
    logic        ready;
    logic        avail;
    logic [2:0]  gid;
    logic [7:0]  rdv;
    logic [31:0] data;
  } vec_t;

  logic [31:0] fq [N][$];
  logic [31:0] exp_q [$];
  vec_t        tab [$];
  logic [N-1:0] rd_snap;
  int checks   = 0;
  int failures = 0;

  function automatic logic [31:0] w(input int i, input int n);
    return {8'hC0, 8'(i), 16'(n)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      fifo_empty[i] = (fq[i].size() == 0);
      fifo_data[32*i +: 32] = (fq[i].size() == 0) ? 32'h0 : fq[i][0];
    end
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < N; i++) fq[i].delete();
    refresh();
  endtask

  // outputs are sampled on the falling edge
  task automatic settle();
    @(negedge clk);
  endtask

  // snapshot pops, check their legality, then apply them after the edge
  task automatic advance();
    rd_snap = fifo_rd;
    if (rd_snap != '0) begin
      chk("pop_onehot", 32'($onehot(rd_snap)), 32'd1);
      for (int i = 0; i < N; i++)
        if (rd_snap[i]) chk($sformatf("pop_nonempty[%0d]", i), 32'(fq[i].size() > 0), 32'd1);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (rd_snap[i] && fq[i].size() > 0) void'(fq[i].pop_front());
    refresh();
  endtask

  task automatic do_reset(input logic [7:0] init);
    rst = 1'b1;
    fifo_init_done = init;
    read_periph_data = 1'b0;
    refresh();
    settle();
    advance();
    settle();
    advance();
    rst = 1'b0;
  endtask

  function automatic void add(input logic rd, input logic [7:0] init, input logic ready,
                              input logic avail, input logic [2:0] gid, input logic [7:0] rdv,
                              input logic [31:0] data);
    vec_t v;
    v.rd = rd; v.init = init; v.ready = ready; v.avail = avail;
    v.gid = gid; v.rdv = rdv; v.data = data;
    tab.push_back(v);
  endfunction

  task automatic run_table(input string name);
    for (int i = 0; i < tab.size(); i++) begin
      read_periph_data = tab[i].rd;
      fifo_init_done = tab[i].init;
      settle();
      chk($sformatf("%s[%0d].ready", name, i), 32'(periph_ready), 32'(tab[i].ready));
      chk($sformatf("%s[%0d].avail", name, i), 32'(periph_data_available), 32'(tab[i].avail));
      chk($sformatf("%s[%0d].gid", name, i), 32'(grant_id), 32'(tab[i].gid));
      chk($sformatf("%s[%0d].rd", name, i), 32'(fifo_rd), 32'(tab[i].rdv));
      chk($sformatf("%s[%0d].data", name, i), data_o, tab[i].data);
      advance();
    end
  endtask

  initial begin
    int nd;
    int last_cyc;
    int exp_gap;
    logic [31:0] e;

    rst = 1'b1;
    read_periph_data = 1'b0;
    fifo_init_done = '0;
    clear_fifos();

    // reset state
    settle();
    advance();
    settle();
    chk("reset.rd", 32'(fifo_rd), 32'h0);
    chk("reset.avail", 32'(periph_data_available), 32'h0);
    chk("reset.data", data_o, 32'h0);
    chk("reset.gid", 32'(grant_id), 32'h0);
    chk("reset.ready", 32'(periph_ready), 32'h0);
    advance();

    // init gating: bits rise one per cycle while FIFO 3 holds data
    clear_fifos();
    fq[3].push_back(w(3, 0));
    fq[3].push_back(w(3, 1));
    do_reset(8'h00);
    tab.delete();
    for (int k = 0; k < 8; k++)
      add(1'b1, 8'((1 << (k + 1)) - 1), 1'b0, 1'b0, 3'd0, 8'h00, 32'h0);
    add(1'b1, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, 32'h0);
    add(1'b1, 8'hFF, 1'b1, 1'b1, 3'd3, 8'h08, w(3, 0));
    add(1'b1, 8'hFF, 1'b1, 1'b1, 3'd3, 8'h08, w(3, 1));
    add(1'b1, 8'hFF, 1'b1, 1'b0, 3'd3, 8'h00, 32'h0);
    add(1'b1, 8'hFF, 1'b1, 1'b0, 3'd3, 8'h00, 32'h0);
    run_table("init");

    // round-robin over FIFOs 1, 4, 6
    clear_fifos();
    for (int n = 0; n < 2; n++) begin
      fq[1].push_back(w(1, n));
      fq[4].push_back(w(4, n));
      fq[6].push_back(w(6, n));
    end
    do_reset(8'hFF);
    tab.delete();
    add(1'b1, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h00, 32'h0);
    add(1'b1, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, 32'h0);
    add(1'b1, 8'hFF, 1'b1, 1'b1, 3'd1, 8'h02, w(1, 0));
    add(1'b1, 8'hFF, 1'b1, 1'b1, 3'd1, 8'h02, w(1, 1));
    add(1'b1, 8'hFF, 1'b1, 1'b0, 3'd1, 8'h00, 32'h0);
    add(1'b1, 8'hFF, 1'b1, 1'b0, 3'd1, 8'h00, 32'h0);
    add(1'b1, 8'hFF, 1'b1, 1'b1, 3'd4, 8'h10, w(4, 0));
    add(1'b1, 8'hFF, 1'b1, 1'b1, 3'd4, 8'h10, w(4, 1));
    add(1'b1, 8'hFF, 1'b1, 1'b0, 3'd4, 8'h00, 32'h0);
    add(1'b1, 8'hFF, 1'b1, 1'b0, 3'd4, 8'h00, 32'h0);
    add(1'b1, 8'hFF, 1'b1, 1'b1, 3'd6, 8'h40, w(6, 0));
    add(1'b1, 8'hFF, 1'b1, 1'b1, 3'd6, 8'h40, w(6, 1));
    add(1'b1, 8'hFF, 1'b1, 1'b0, 3'd6, 8'h00, 32'h0);
    add(1'b1, 8'hFF, 1'b1, 1'b0, 3'd6, 8'h00, 32'h0);
    run_table("rr");

    // backpressure on FIFO 2
    clear_fifos();
    for (int n = 0; n < 4; n++) fq[2].push_back(w(2, n));
    do_reset(8'hFF);
    tab.delete();
    add(1'b1, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h00, 32'h0);
    add(1'b1, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, 32'h0);
    add(1'b1, 8'hFF, 1'b1, 1'b1, 3'd2, 8'h04, w(2, 0));
    add(1'b0, 8'hFF, 1'b1, 1'b1, 3'd2, 8'h00, w(2, 1));
    add(1'b0, 8'hFF, 1'b1, 1'b1, 3'd2, 8'h00, w(2, 1));
    add(1'b1, 8'hFF, 1'b1, 1'b1, 3'd2, 8'h04, w(2, 1));
    add(1'b1, 8'hFF, 1'b1, 1'b1, 3'd2, 8'h04, w(2, 2));
    add(1'b0, 8'hFF, 1'b1, 1'b1, 3'd2, 8'h00, w(2, 3));
    add(1'b1, 8'hFF, 1'b1, 1'b1, 3'd2, 8'h04, w(2, 3));
    add(1'b1, 8'hFF, 1'b1, 1'b0, 3'd2, 8'h00, 32'h0);
    add(1'b1, 8'hFF, 1'b1, 1'b0, 3'd2, 8'h00, 32'h0);
    run_table("bp");

    // wrap from last_grant=7 and readiness loss mid-burst
    clear_fifos();
    for (int n = 0; n < 10; n++) fq[0].push_back(w(0, n));
    fq[7].push_back(w(7, 0));
    fq[7].push_back(w(7, 1));
    do_reset(8'hFF);
    tab.delete();
    add(1'b1, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h00, 32'h0);
    add(1'b1, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, 32'h0);
    add(1'b1, 8'hFF, 1'b1, 1'b1, 3'd0, 8'h01, w(0, 0));
    add(1'b1, 8'hDF, 1'b1, 1'b1, 3'd0, 8'h01, w(0, 1));
    add(1'b1, 8'hDF, 1'b0, 1'b0, 3'd0, 8'h00, w(0, 2));
    add(1'b1, 8'hDF, 1'b0, 1'b0, 3'd0, 8'h00, 32'h0);
    add(1'b1, 8'hDF, 1'b0, 1'b0, 3'd0, 8'h00, 32'h0);
    add(1'b1, 8'hFF, 1'b0, 1'b0, 3'd0, 8'h00, 32'h0);
    add(1'b1, 8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, 32'h0);
    add(1'b1, 8'hFF, 1'b1, 1'b1, 3'd7, 8'h80, w(7, 0));
    add(1'b1, 8'hFF, 1'b1, 1'b1, 3'd7, 8'h80, w(7, 1));
    add(1'b1, 8'hFF, 1'b1, 1'b0, 3'd7, 8'h00, 32'h0);
    add(1'b1, 8'hFF, 1'b1, 1'b0, 3'd7, 8'h00, 32'h0);
    add(1'b1, 8'hFF, 1'b1, 1'b1, 3'd0, 8'h01, w(0, 2));
    run_table("wrap");

    // burst cap: FIFO 0 holds 40 words, FIFO 2 holds 5
    clear_fifos();
    exp_q.delete();
    for (int n = 0; n < 40; n++) fq[0].push_back(w(0, n));
    for (int n = 0; n < 5; n++) fq[2].push_back(w(2, n));
    for (int n = 0; n < 16; n++) exp_q.push_back(w(0, n));
    for (int n = 0; n < 5; n++) exp_q.push_back(w(2, n));
    for (int n = 16; n < 40; n++) exp_q.push_back(w(0, n));
    do_reset(8'hFF);
    read_periph_data = 1'b1;
    nd = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 200 && exp_q.size() > 0; cyc++) begin
      settle();
      if (periph_data_available && read_periph_data) begin
        e = exp_q.pop_front();
        chk($sformatf("burst word %0d", nd), data_o, e);
        chk($sformatf("burst gid %0d", nd), 32'(grant_id), 32'(e[23:16]));
        if (nd > 0) begin
          exp_gap = (nd == 16 || nd == 37) ? 2 : (nd == 21) ? 3 : 1;
          chk($sformatf("burst gap %0d", nd), 32'(cyc - last_cyc), 32'(exp_gap));
        end
        last_cyc = cyc;
        nd++;
      end
      advance();
    end
    chk("burst delivered", 32'(nd), 32'd45);

    // reset asserted during the 5th word of a burst
    clear_fifos();
    for (int n = 0; n < 10; n++) fq[1].push_back(w(1, n));
    fq[5].push_back(w(5, 0));
    do_reset(8'hFF);
    read_periph_data = 1'b1;
    for (int c = 0; c < 6; c++) begin
      settle();
      advance();
    end
    rst = 1'b1;
    settle();
    chk("rstmid.data_5th", data_o, w(1, 4));
    chk("rstmid.no_pop", 32'(fifo_rd), 32'h0);
    advance();
    rst = 1'b0;
    settle();
    chk("rstmid.rd", 32'(fifo_rd), 32'h0);
    chk("rstmid.avail", 32'(periph_data_available), 32'h0);
    chk("rstmid.data", data_o, 32'h0);
    chk("rstmid.gid", 32'(grant_id), 32'h0);
    chk("rstmid.ready", 32'(periph_ready), 32'h0);
    chk("rstmid.fifo1_left", 32'(fq[1].size()), 32'd6);
    advance();
    settle();
    chk("rstmid.idle_ready", 32'(periph_ready), 32'd1);
    chk("rstmid.idle_avail", 32'(periph_data_available), 32'h0);
    advance();
    settle();
    chk("rstmid.regrant_gid", 32'(grant_id), 32'd1);
    chk("rstmid.regrant_data", data_o, w(1, 4));
    chk("rstmid.regrant_avail", 32'(periph_data_available), 32'd1);
    advance();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
